// File: rtl/equiv_miscompare_monitor_if.sv
// Sample bus from the two-copy equivalence harness: run request, qualifier and both result copies.
// The harness side drives it (master); the monitor only observes it (slave).
interface equiv_miscompare_monitor_if #(
    parameter int WIDTH = 91
);
    logic             start;
    logic             y_valid;
    logic [WIDTH-1:0] y_1;
    logic [WIDTH-1:0] y_2;

    modport master (output start, output y_valid, output y_1, output y_2);
    modport slave  (input  start, input  y_valid, input  y_1, input  y_2);
endinterface

// File: rtl/equiv_miscompare_monitor.sv
// Compares the paired harness result buses after a warm-up window, up to a fixed sample budget.
// Keeps the first miscompare (index and XOR difference) and a saturating miscompare count.
module equiv_miscompare_monitor #(
    parameter int WIDTH        = 91,
    parameter int WARMUP       = 4,
    parameter int BUDGET       = 1000,
    parameter int CNT_W        = 16,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    equiv_miscompare_monitor_if.slave bus,
    output logic                      busy,
    output logic                      done,
    output logic                      fail,
    output logic [CNT_W-1:0]          cycle_cnt,
    output logic [CNT_W-1:0]          fail_cycle,
    output logic [WIDTH-1:0]          fail_diff,
    output logic [CNT_W-1:0]          mismatch_cnt,
    output logic [1:0]                fsm_state
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WARM_LAST = (WARMUP > 0) ? CNT_W'(WARMUP - 1) : '0;
    localparam logic [CNT_W-1:0] BUDGET_V  = CNT_W'(BUDGET);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] warm_cnt;
    logic [CNT_W-1:0] cycle_next;
    logic [WIDTH-1:0] diff;
    logic             miscmp;
    logic             accept;
    logic             take;

    assign diff       = bus.y_1 ^ bus.y_2;
    assign miscmp     = |diff;
    assign cycle_next = cycle_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // accept: run request taken this edge; take: a checked sample is consumed this edge.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        take       = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = (WARMUP == 0) ? ST_CHECK : ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (bus.y_valid && (warm_cnt == WARM_LAST)) next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (bus.y_valid) begin
                    take = 1'b1;
                    if ((cycle_next == BUDGET_V) || ((STOP_ON_FAIL != 0) && miscmp))
                        next_state = ST_DONE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt     <= '0;
            cycle_cnt    <= '0;
            fail         <= 1'b0;
            fail_cycle   <= '0;
            fail_diff    <= '0;
            mismatch_cnt <= '0;
        end else if (accept) begin
            warm_cnt     <= '0;
            cycle_cnt    <= '0;
            fail         <= 1'b0;
            fail_cycle   <= '0;
            fail_diff    <= '0;
            mismatch_cnt <= '0;
        end else begin
            if ((state == ST_WARMUP) && bus.y_valid) warm_cnt <= warm_cnt + 1'b1;
            if (take) begin
                cycle_cnt <= cycle_next;
                if (miscmp) begin
                    if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
                    // Only the first miscompare of a run is recorded.
                    if (!fail) begin
                        fail       <= 1'b1;
                        fail_cycle <= cycle_cnt;
                        fail_diff  <= diff;
                    end
                end
            end
        end
    end

    assign busy      = (state == ST_WARMUP) || (state == ST_CHECK);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;
endmodule

// File: tb/tb_equiv_miscompare_monitor.sv
// Directed bench for equiv_miscompare_monitor: one instance stops on first fail, one runs the full budget.
module tb_equiv_miscompare_monitor;
    localparam int W  = 91;
    localparam int CW = 16;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    equiv_miscompare_monitor_if #(.WIDTH(W)) bus ();

    logic          busy_s, done_s, fail_s, busy_c, done_c, fail_c;
    logic [CW-1:0] cyc_s, fcyc_s, mm_s, cyc_c, fcyc_c, mm_c;
    logic [W-1:0]  fdiff_s, fdiff_c;
    logic [1:0]    st_s, st_c;

    equiv_miscompare_monitor #(.WIDTH(W), .WARMUP(4), .BUDGET(1000), .CNT_W(CW), .STOP_ON_FAIL(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .busy(busy_s), .done(done_s), .fail(fail_s), .cycle_cnt(cyc_s), .fail_cycle(fcyc_s),
        .fail_diff(fdiff_s), .mismatch_cnt(mm_s), .fsm_state(st_s)
    );

    equiv_miscompare_monitor #(.WIDTH(W), .WARMUP(4), .BUDGET(1000), .CNT_W(CW), .STOP_ON_FAIL(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .busy(busy_c), .done(done_c), .fail(fail_c), .cycle_cnt(cyc_c), .fail_cycle(fcyc_c),
        .fail_diff(fdiff_c), .mismatch_cnt(mm_c), .fsm_state(st_c)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rnd();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // Driver tasks: inputs change 1 time unit after the rising edge, outputs are read there too.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.y_valid = v;
        bus.y_1     = a;
        bus.y_2     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step(1'b1, 91'h5, 91'h6);
        bus.start = 1'b0;
    endtask

    task automatic finish_clean(output int n);
        logic [W-1:0] r;
        n = 0;
        while ((busy_s || busy_c) && n < 3000) begin
            r = rnd();
            step(1'b1, r, r);
            n++;
        end
        compared++;
        if (busy_s || busy_c) begin
            mismatched++;
            $display("FAIL run_timeout: still busy after %0d samples, required done", n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.start = 1'b0; bus.y_valid = 1'b0; bus.y_1 = '0; bus.y_2 = '0;
        #3 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        compared++;
        if ({busy_s, done_s, fail_s, cyc_s, fcyc_s, mm_s, st_s} !== '0 || fdiff_s !== '0) begin
            mismatched++;
            $display("FAIL reset_s: busy=%b done=%b fail=%b cyc=%0d st=%0d, required all 0", busy_s, done_s, fail_s, cyc_s, st_s);
        end
        compared++;
        if ({busy_c, done_c, fail_c, cyc_c, fcyc_c, mm_c, st_c} !== '0 || fdiff_c !== '0) begin
            mismatched++;
            $display("FAIL reset_c: busy=%b done=%b fail=%b cyc=%0d st=%0d, required all 0", busy_c, done_c, fail_c, cyc_c, st_c);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_clean();
        int n;
        do_start();
        compared++;
        if (busy_s !== 1'b1 || done_s !== 1'b0) begin
            mismatched++;
            $display("FAIL clean_busy_rise: busy=%b done=%b, required 1/0", busy_s, done_s);
        end
        finish_clean(n);
        compared++;
        if (n !== 1004) begin
            mismatched++;
            $display("FAIL clean_busy_len: %0d cycles, required 1004", n);
        end
        compared++;
        if (done_s !== 1'b1 || fail_s !== 1'b0 || cyc_s !== 16'd1000 || mm_s !== 16'd0) begin
            mismatched++;
            $display("FAIL clean_result_s: done=%b fail=%b cyc=%0d mm=%0d, required 1/0/1000/0", done_s, fail_s, cyc_s, mm_s);
        end
        compared++;
        if (done_c !== 1'b1 || fail_c !== 1'b0 || cyc_c !== 16'd1000 || mm_c !== 16'd0) begin
            mismatched++;
            $display("FAIL clean_result_c: done=%b fail=%b cyc=%0d mm=%0d, required 1/0/1000/0", done_c, fail_c, cyc_c, mm_c);
        end
    endtask

    task automatic test_warmup_mask();
        int n;
        logic [W-1:0] r;
        do_start();
        for (int k = 0; k < 4; k++) begin
            r = rnd();
            step(1'b1, r, ~r);
        end
        finish_clean(n);
        compared++;
        if (n !== 1000) begin
            mismatched++;
            $display("FAIL warm_len: %0d checked samples, required 1000", n);
        end
        compared++;
        if (fail_s !== 1'b0 || mm_s !== 16'd0 || fail_c !== 1'b0 || mm_c !== 16'd0) begin
            mismatched++;
            $display("FAIL warm_mask: fail=%b/%b mm=%0d/%0d, required 0/0 0/0", fail_s, fail_c, mm_s, mm_c);
        end
    endtask

    task automatic test_stop_on_fail();
        int n;
        logic [W-1:0] r;
        do_start();
        for (int k = 0; k < 11; k++) begin
            r = rnd();
            step(1'b1, r, r);
        end
        compared++;
        if (done_s !== 1'b0 || cyc_s !== 16'd7) begin
            mismatched++;
            $display("FAIL stop_pre: done=%b cyc=%0d, required 0/7", done_s, cyc_s);
        end
        r = rnd();
        step(1'b1, r, r ^ 91'h1);
        compared++;
        if (done_s !== 1'b1 || fail_s !== 1'b1 || fcyc_s !== 16'd7 || fdiff_s !== 91'h1 || cyc_s !== 16'd8 || mm_s !== 16'd1) begin
            mismatched++;
            $display("FAIL stop_result: done=%b fail=%b fcyc=%0d diff=%h cyc=%0d mm=%0d, required 1/1/7/1/8/1",
                     done_s, fail_s, fcyc_s, fdiff_s, cyc_s, mm_s);
        end
        finish_clean(n);
        compared++;
        if (n !== 992 || cyc_s !== 16'd8 || done_s !== 1'b1) begin
            mismatched++;
            $display("FAIL stop_hold: extra=%0d cyc_s=%0d done_s=%b, required 992/8/1", n, cyc_s, done_s);
        end
        compared++;
        if (fail_c !== 1'b1 || fcyc_c !== 16'd7 || fdiff_c !== 91'h1 || cyc_c !== 16'd1000 || mm_c !== 16'd1) begin
            mismatched++;
            $display("FAIL stop_other_c: fail=%b fcyc=%0d diff=%h cyc=%0d mm=%0d, required 1/7/1/1000/1",
                     fail_c, fcyc_c, fdiff_c, cyc_c, mm_c);
        end
    endtask

    task automatic test_continue_on_fail();
        logic [W-1:0] r;
        logic [W-1:0] d;
        do_start();
        for (int k = 0; k < 4; k++) begin
            r = rnd();
            step(1'b1, r, r);
        end
        for (int k = 0; k < 1000; k++) begin
            r = rnd();
            d = (k == 3) ? 91'h10 : (k == 500) ? 91'h2 : 91'h0;
            step(1'b1, r, r ^ d);
            if (k == 3) begin
                compared++;
                if (done_s !== 1'b1 || fcyc_s !== 16'd3 || cyc_s !== 16'd4 || fdiff_s !== 91'h10) begin
                    mismatched++;
                    $display("FAIL cont_stop_s: done=%b fcyc=%0d cyc=%0d diff=%h, required 1/3/4/10", done_s, fcyc_s, cyc_s, fdiff_s);
                end
            end
            if (k == 501) begin
                compared++;
                if (mm_c !== 16'd2 || fdiff_c !== 91'h10 || busy_c !== 1'b1) begin
                    mismatched++;
                    $display("FAIL cont_mid_c: mm=%0d diff=%h busy=%b, required 2/10/1", mm_c, fdiff_c, busy_c);
                end
            end
        end
        compared++;
        if (done_c !== 1'b1 || fcyc_c !== 16'd3 || fdiff_c !== 91'h10 || mm_c !== 16'd2 || cyc_c !== 16'd1000) begin
            mismatched++;
            $display("FAIL cont_result_c: done=%b fcyc=%0d diff=%h mm=%0d cyc=%0d, required 1/3/10/2/1000",
                     done_c, fcyc_c, fdiff_c, mm_c, cyc_c);
        end
    endtask

    task automatic test_gaps_and_start();
        int i;
        logic [W-1:0] r;
        do_start();
        i = 0;
        while (!done_c && i < 5000) begin
            r = rnd();
            bus.start = (i == 1001);
            step(i[0], r, r);
            bus.start = 1'b0;
            if (i == 1001) begin
                compared++;
                if (cyc_c !== 16'd497 || busy_c !== 1'b1 || cyc_s !== 16'd497) begin
                    mismatched++;
                    $display("FAIL gap_start_ignored: cyc=%0d/%0d busy=%b, required 497/497/1", cyc_c, cyc_s, busy_c);
                end
            end
            if (i == 1002) begin
                compared++;
                if (cyc_c !== 16'd497) begin
                    mismatched++;
                    $display("FAIL gap_hold: cyc=%0d, required 497", cyc_c);
                end
            end
            i++;
        end
        compared++;
        if (i !== 2008 || cyc_c !== 16'd1000 || done_s !== 1'b1 || fail_c !== 1'b0) begin
            mismatched++;
            $display("FAIL gap_len: cycles=%0d cyc=%0d done_s=%b fail=%b, required 2008/1000/1/0", i, cyc_c, done_s, fail_c);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        logic [W-1:0] r;
        do_start();
        for (int k = 0; k < 24; k++) begin
            r = rnd();
            step(1'b1, r, (k == 9) ? ~r : r);
        end
        compared++;
        if (fail_c !== 1'b1 || cyc_c !== 16'd20 || fcyc_c !== 16'd5) begin
            mismatched++;
            $display("FAIL rst_pre: fail=%b cyc=%0d fcyc=%0d, required 1/20/5", fail_c, cyc_c, fcyc_c);
        end
        bus.y_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({busy_c, done_c, fail_c, cyc_c, fcyc_c, mm_c, st_c} !== '0 || fdiff_c !== '0
            || {busy_s, done_s, fail_s, cyc_s, fcyc_s, mm_s, st_s} !== '0 || fdiff_s !== '0) begin
            mismatched++;
            $display("FAIL rst_mid: c busy=%b fail=%b cyc=%0d st=%0d; s done=%b fail=%b st=%0d, required all 0",
                     busy_c, fail_c, cyc_c, st_c, done_s, fail_s, st_s);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.y_valid = 1'b0;
        @(posedge clk); #1;
        do_start();
        finish_clean(n);
        compared++;
        if (n !== 1004 || fail_c !== 1'b0 || cyc_c !== 16'd1000 || mm_c !== 16'd0 || done_c !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_rerun: len=%0d fail=%b cyc=%0d mm=%0d done=%b, required 1004/0/1000/0/1", n, fail_c, cyc_c, mm_c, done_c);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_clean();
        test_warmup_mask();
        test_stop_on_fail();
        test_continue_on_fail();
        test_gaps_and_start();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
